// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one shared inverse-round datapath, NR+1 cycles per block.
// Round keys are read combinationally from an external store via key_addr/key_data.
module aes_inv_cipher_iter #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_addr,
  input  logic [127:0] key_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  // Inverse S-box; element index is the complement of the input byte.
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  state_e        fsm_q, fsm_d;
  logic [127:0]  state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [127:0]  out_data_q, out_data_d;

  logic [127:0]  xor_src, xor_out, mix_out, round_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      o[8*(15-4*c) +: 8] = gm(a0, 4'd14) ^ gm(a1, 4'd11) ^ gm(a2, 4'd13) ^ gm(a3, 4'd9);
      o[8*(14-4*c) +: 8] = gm(a0, 4'd9)  ^ gm(a1, 4'd14) ^ gm(a2, 4'd11) ^ gm(a3, 4'd13);
      o[8*(13-4*c) +: 8] = gm(a0, 4'd13) ^ gm(a1, 4'd9)  ^ gm(a2, 4'd14) ^ gm(a3, 4'd11);
      o[8*(12-4*c) +: 8] = gm(a0, 4'd11) ^ gm(a1, 4'd13) ^ gm(a2, 4'd9)  ^ gm(a3, 4'd14);
    end
    return o;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int unsigned  r, c, src;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      r   = i % 4;
      c   = i / 4;
      src = r + 4 * ((c + 4 - r) % 4);
      o[8*(15-i) +: 8] = s[8*(15-src) +: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      o[8*i +: 8] = INV_SBOX[~s[8*i +: 8]];
    end
    return o;
  endfunction

  // IDLE feeds the first round (no InvMixColumns); FINAL reuses the key XOR alone.
  always_comb begin
    xor_src   = (fsm_q == IDLE) ? in_data : state_q;
    xor_out   = xor_src ^ key_data;
    mix_out   = (fsm_q == IDLE) ? xor_out : inv_mix_columns(xor_out);
    round_out = inv_sub_bytes(inv_shift_rows(mix_out));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      rnd_q      <= '0;
      out_data_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    rnd_d      = rnd_q;
    out_data_d = out_data_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = round_out;
          rnd_d   = 4'(NR - 1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        if (rnd_q == 4'd1) fsm_d = FINAL;
        else               rnd_d = rnd_q - 4'd1;
      end
      FINAL: begin
        out_data_d = xor_out;
        fsm_d      = DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    key_addr  = 4'd0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        key_addr = 4'(NR);
      end
      ROUND:   key_addr = rnd_q;
      FINAL:   key_addr = 4'd0;
      DONE:    out_valid = 1'b1;
      default: key_addr = 4'd0;
    endcase
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter at NR=10/12/14 with bench-built key schedules.
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] in_data;
  logic         in_valid_a  [3];
  logic         out_ready_a [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic         busy_a      [3];
  logic [3:0]   key_addr_a  [3];
  logic [127:0] key_data_a  [3];
  logic [127:0] out_data_a  [3];

  logic [127:0] rk [3][16];
  logic [7:0]   sbox_t [256];

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_inv_cipher_iter #(.NR(10)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_data(in_data),
    .key_addr(key_addr_a[0]), .key_data(key_data_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .out_data(out_data_a[0]), .busy(busy_a[0]));
  aes_inv_cipher_iter #(.NR(12)) u_dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_data(in_data),
    .key_addr(key_addr_a[1]), .key_data(key_data_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .out_data(out_data_a[1]), .busy(busy_a[1]));
  aes_inv_cipher_iter #(.NR(14)) u_dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_data(in_data),
    .key_addr(key_addr_a[2]), .key_data(key_data_a[2]), .out_valid(out_valid_a[2]),
    .out_ready(out_ready_a[2]), .out_data(out_data_a[2]), .busy(busy_a[2]));

  assign key_data_a[0] = rk[0][key_addr_a[0]];
  assign key_data_a[1] = rk[1][key_addr_a[1]];
  assign key_data_a[2] = rk[2][key_addr_a[2]];

  function automatic int nr_of(input int sel);
    return 10 + 2 * sel;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Forward S-box from the GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sbox_t[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic load_keys(input int sel, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nr, nk;
    nr = nr_of(sel);
    nk = nr - 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]});
        t[31:24] ^= rcon;
        rcon = xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[sel][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Forward cipher used only to produce extra ciphertexts from known plaintexts.
  function automatic logic [127:0] encrypt(input int sel, input logic [127:0] pt);
    logic [127:0] s, o;
    logic [7:0]   a0, a1, a2, a3;
    int nr;
    nr = nr_of(sel);
    s = pt ^ rk[sel][0];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = sbox_t[s[8*i +: 8]];
      for (int i = 0; i < 16; i++)
        o[8*(15-i) +: 8] = s[8*(15-((i % 4) + 4 * (((i / 4) + (i % 4)) % 4))) +: 8];
      s = o;
      if (rd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[8*(15-4*c) +: 8]; a1 = s[8*(14-4*c) +: 8];
          a2 = s[8*(13-4*c) +: 8]; a3 = s[8*(12-4*c) +: 8];
          o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        s = o;
      end
      s ^= rk[sel][rd];
    end
    return s;
  endfunction

  task automatic run_block(input int sel, input logic [127:0] ct, input logic [127:0] pt,
                           input bit handshake, input string name);
    int nr, k, exp_addr;
    bit seen;
    nr = nr_of(sel);
    checks++;
    if (in_ready_a[sel] !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready_a[sel]);
    end
    checks++;
    if (key_addr_a[sel] !== 4'(nr)) begin
      errors++; $display("FAIL %s_idle_key_addr: got %0d expected %0d", name, key_addr_a[sel], nr);
    end
    in_data = ct;
    in_valid_a[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[sel] = 1'b0;
    k = 0;
    seen = 1'b0;
    while (k <= nr + 5) begin
      if (out_valid_a[sel]) begin
        seen = 1'b1;
        break;
      end
      exp_addr = (k < nr - 1) ? nr - 1 - k : 0;
      checks++;
      if (key_addr_a[sel] !== 4'(exp_addr)) begin
        errors++;
        $display("FAIL %s_key_addr[%0d]: got %0d expected %0d", name, k, key_addr_a[sel], exp_addr);
      end
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (!seen || k != nr) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges (seen=%b) expected %0d", name, k, seen, nr);
    end
    checks++;
    if (out_data_a[sel] !== pt) begin
      errors++; $display("FAIL %s_out_data: got %h expected %h", name, out_data_a[sel], pt);
    end
    if (handshake) begin
      out_ready_a[sel] = 1'b1;
      @(posedge clk); #1;
      out_ready_a[sel] = 1'b0;
      checks++;
      if (out_valid_a[sel] !== 1'b0 || in_ready_a[sel] !== 1'b1) begin
        errors++;
        $display("FAIL %s_handshake: got out_valid=%b in_ready=%b expected 0/1",
                 name, out_valid_a[sel], in_ready_a[sel]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (in_ready_a[s] !== 1'b1 || out_valid_a[s] !== 1'b0 || busy_a[s] !== 1'b0 ||
          out_data_a[s] !== '0 || key_addr_a[s] !== 4'(nr_of(s))) begin
        errors++;
        $display("FAIL reset_state[%0d]: got rdy=%b vld=%b busy=%b data=%h addr=%0d expected 1/0/0/0/%0d",
                 s, in_ready_a[s], out_valid_a[s], busy_a[s], out_data_a[s], key_addr_a[s], nr_of(s));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_aes128();
    run_block(0, CT128, PT0, 1'b1, "aes128");
  endtask

  task automatic test_aes192();
    run_block(1, CT192, PT0, 1'b1, "aes192");
  endtask

  task automatic test_aes256();
    run_block(2, CT256, PT0, 1'b1, "aes256");
  endtask

  task automatic test_backpressure();
    run_block(0, CT128, PT0, 1'b0, "bp");
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0 || busy_a[0] !== 1'b1 ||
          out_data_a[0] !== PT0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b busy=%b data=%h expected 1/0/1/%h",
                 i, out_valid_a[0], in_ready_a[0], busy_a[0], out_data_a[0], PT0);
      end
      in_valid_a[0] = i[0];
      in_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid_a[0] = 1'b0;
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
    checks++;
    if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1 || out_data_a[0] !== PT0) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b data=%h expected 0/1/%h",
               out_valid_a[0], in_ready_a[0], out_data_a[0], PT0);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_a[0] !== 1'b0) begin
      errors++; $display("FAIL bp_no_accept: got busy=%b expected 0", busy_a[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct [3];
    logic [127:0] pt [3];
    int acc_cyc [3];
    int cyc, acc, got;
    bit accepting;
    pt[0] = PT0; pt[1] = PT1; pt[2] = PT2;
    ct[0] = CT128;
    ct[1] = encrypt(0, PT1);
    ct[2] = encrypt(0, PT2);
    cyc = 0; acc = 0; got = 0;
    in_data = ct[0];
    in_valid_a[0] = 1'b1;
    out_ready_a[0] = 1'b1;
    while (got < 3 && cyc < 200) begin
      accepting = in_ready_a[0] && in_valid_a[0];
      if (out_valid_a[0]) begin
        checks++;
        if (out_data_a[0] !== pt[got]) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %h expected %h", got, out_data_a[0], pt[got]);
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepting) begin
        acc_cyc[acc] = cyc;
        acc++;
        if (acc < 3) in_data = ct[acc];
        else in_valid_a[0] = 1'b0;
      end
    end
    in_valid_a[0] = 1'b0;
    out_ready_a[0] = 1'b0;
    checks++;
    if (got != 3 || acc != 3) begin
      errors++; $display("FAIL b2b_count: got %0d outputs %0d accepts expected 3/3", got, acc);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 12) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d expected 12", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n;
    in_data = CT128;
    in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    n = 0;
    while (key_addr_a[0] !== 4'd5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (key_addr_a[0] !== 4'd5) begin
      errors++; $display("FAIL rstmid_reach_rnd5: got key_addr=%0d expected 5", key_addr_a[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0 || out_data_a[0] !== '0 ||
        busy_a[0] !== 1'b0 || key_addr_a[0] !== 4'd10) begin
      errors++;
      $display("FAIL rstmid_state: got rdy=%b vld=%b data=%h busy=%b addr=%0d expected 1/0/0/0/10",
               in_ready_a[0], out_valid_a[0], out_data_a[0], busy_a[0], key_addr_a[0]);
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_a[0] !== 1'b0) begin
        errors++; $display("FAIL rstmid_no_pulse[%0d]: got %b expected 0", i, out_valid_a[0]);
      end
    end
    run_block(0, CT128, PT0, 1'b1, "rstmid_after");
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 50; i++) begin
      out_ready_a[0] = i[0];
      @(posedge clk); #1;
      checks++;
      if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1 ||
          out_data_a[0] !== PT0) begin
        errors++;
        $display("FAIL idle_noise[%0d]: got vld=%b busy=%b rdy=%b data=%h expected 0/0/1/%h",
                 i, out_valid_a[0], busy_a[0], in_ready_a[0], out_data_a[0], PT0);
      end
    end
    out_ready_a[0] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    for (int s = 0; s < 3; s++) begin
      in_valid_a[s] = 1'b0;
      out_ready_a[s] = 1'b0;
    end
    build_sbox();
    load_keys(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    load_keys(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    load_keys(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_idle_noise();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
